// File: rtl/wb_stage_mlane.sv
// Multi-lane write-back stage: registers MEM/WB results, extends sub-word loads,
// resolves same-rd conflicts between lanes and counts retired instructions.
module wb_stage_mlane #(
  parameter int XLEN       = 32,
  parameter int LANES      = 2,
  parameter int STALL_MODE = 0,
  parameter int CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  combined_stall,
  input  logic [LANES-1:0]      in_valid,
  input  logic [LANES*XLEN-1:0] in_pc,
  input  logic [LANES*XLEN-1:0] in_rdata,
  input  logic [LANES*XLEN-1:0] in_alu,
  input  logic [LANES*5-1:0]    in_rd,
  input  logic [LANES-1:0]      in_regwrite,
  input  logic [LANES-1:0]      in_memtoreg,
  input  logic [LANES*3-1:0]    in_ldtype,
  input  logic [LANES*3-1:0]    in_boff,
  output logic [LANES-1:0]      wb_valid,
  output logic [LANES-1:0]      wb_regwrite,
  output logic [LANES*5-1:0]    wb_rd,
  output logic [LANES*XLEN-1:0] wb_wdata,
  output logic [LANES*XLEN-1:0] wb_pc,
  output logic [CNT_W-1:0]      retire_count
);

  // Offsets beyond the native word are dropped; unknown funct3 codes pass the word through.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] w,
                                               input logic [2:0] t,
                                               input logic [2:0] off);
    logic [2:0]      b_off, h_off, w_off;
    logic [XLEN-1:0] sh_b, sh_h, sh_w, r;
    b_off = (XLEN == 64) ? off : {1'b0, off[1:0]};
    h_off = {b_off[2:1], 1'b0};
    w_off = (XLEN == 64) ? {off[2], 2'b00} : 3'b000;
    sh_b  = w >> {b_off, 3'b000};
    sh_h  = w >> {h_off, 3'b000};
    sh_w  = w >> {w_off, 3'b000};
    r     = w;
    case (t)
      3'b000, 3'b100: begin
        r = '0;
        r[7:0] = sh_b[7:0];
        if (!t[2]) for (int k = 8; k < XLEN; k++) r[k] = sh_b[7];
      end
      3'b001, 3'b101: begin
        r = '0;
        r[15:0] = sh_h[15:0];
        if (!t[2]) for (int k = 16; k < XLEN; k++) r[k] = sh_h[15];
      end
      3'b010, 3'b110: begin
        if (XLEN == 64) begin
          r = '0;
          r[31:0] = sh_w[31:0];
          if (!t[2]) for (int k = 32; k < XLEN; k++) r[k] = sh_w[31];
        end else begin
          r = w;
        end
      end
      default: r = w;
    endcase
    return r;
  endfunction

  logic [LANES-1:0]      valid_q, regwrite_q;
  logic [LANES*5-1:0]    rd_q;
  logic [LANES*XLEN-1:0] wdata_q, pc_q;
  logic [CNT_W-1:0]      retire_q;

  logic [LANES-1:0]      valid_d, regwrite_d, want_wr;
  logic [LANES*5-1:0]    rd_d;
  logic [LANES*XLEN-1:0] wdata_d, pc_d;
  logic [CNT_W-1:0]      retire_d, pop;

  always_comb begin
    valid_d    = in_valid;
    regwrite_d = '0;
    want_wr    = '0;
    rd_d       = '0;
    wdata_d    = '0;
    pc_d       = '0;
    pop        = '0;
    for (int i = 0; i < LANES; i++) begin
      want_wr[i] = in_valid[i] & in_regwrite[i] & (in_rd[i*5 +: 5] != 5'd0);
      pop        = pop + CNT_W'(in_valid[i]);
      if (in_valid[i]) begin
        rd_d[i*5 +: 5]       = in_rd[i*5 +: 5];
        pc_d[i*XLEN +: XLEN] = in_pc[i*XLEN +: XLEN];
        wdata_d[i*XLEN +: XLEN] = in_memtoreg[i]
          ? load_ext(in_rdata[i*XLEN +: XLEN], in_ldtype[i*3 +: 3], in_boff[i*3 +: 3])
          : in_alu[i*XLEN +: XLEN];
      end
    end
    // Younger (higher-index) lane wins a same-rd write; the older lane stays valid.
    for (int i = 0; i < LANES; i++) begin
      regwrite_d[i] = want_wr[i];
      for (int j = i + 1; j < LANES; j++) begin
        if (want_wr[j] && (in_rd[j*5 +: 5] == in_rd[i*5 +: 5])) regwrite_d[i] = 1'b0;
      end
    end
    retire_d = retire_q + pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      regwrite_q <= '0;
      rd_q       <= '0;
      wdata_q    <= '0;
      pc_q       <= '0;
      retire_q   <= '0;
    end else if (combined_stall) begin
      if (STALL_MODE == 0) begin
        valid_q    <= '0;
        regwrite_q <= '0;
        rd_q       <= '0;
        wdata_q    <= '0;
        pc_q       <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      pc_q       <= pc_d;
      retire_q   <= retire_d;
    end
  end

  assign wb_valid     = valid_q;
  assign wb_regwrite  = regwrite_q;
  assign wb_rd        = rd_q;
  assign wb_wdata     = wdata_q;
  assign wb_pc        = pc_q;
  assign retire_count = retire_q;

endmodule

// File: doc/wb_stage_mlane.md
# wb_stage_mlane

Parametrised multi-lane write-back stage. Registers up to LANES results per cycle from the MEM/WB boundary, selects memory or ALU data, and aligns and sign- or zero-extends sub-word loads. It resolves same-destination conflicts between lanes, supports a selectable stall policy (bubble or hold), and maintains a retired-instruction counter. It sits between the MEM stage and the register-file write ports and forwarding network.

## Interface
- XLEN, 32, datapath width (32 or 64)
- LANES, 2, parallel write-back lanes (1..4)
- STALL_MODE, 0, 0 = insert bubble on stall, 1 = hold previous outputs on stall
- CNT_W, 64, retire counter width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- combined_stall  in  1  pipeline stall
- in_valid  in  LANES  lane carries a real instruction
- in_pc  in  LANES*XLEN  per-lane PC, lane i at [i*XLEN +: XLEN]
- in_rdata  in  LANES*XLEN  raw aligned memory word per lane
- in_alu  in  LANES*XLEN  ALU result per lane
- in_rd  in  LANES*5  destination register per lane
- in_regwrite  in  LANES  register write request
- in_memtoreg  in  LANES  1 = load data, 0 = ALU result
- in_ldtype  in  LANES*3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 110 LWU (XLEN=64), 011 LD (XLEN=64)
- in_boff  in  LANES*3  byte offset within the word (low address bits)
- wb_valid  out  LANES  registered lane valid
- wb_regwrite  out  LANES  final register-file write enable
- wb_rd  out  LANES*5  destination register
- wb_wdata  out  LANES*XLEN  write data
- wb_pc  out  LANES*XLEN  retired PC
- retire_count  out  CNT_W  retired-instruction count

## Operation
- Lane i captured when `!combined_stall`. Outputs: `wb_valid[i]=in_valid[i]`, rd/pc copied, `wb_wdata = memtoreg ? ext(rdata) : alu`.
- Lanes with `in_valid=0` register `wb_valid`, `wb_regwrite`, `wb_rd`, `wb_wdata` and `wb_pc` as 0.
- Load extension uses `in_boff`:
  - LB/LBU select byte `boff`.
  - LH/LHU select halfword `boff[2:1]` (`boff[0]` ignored).
  - LW/LWU select word `boff[2]` (XLEN=64; ignored at XLEN=32).
  - LD/LW at native width ignore `boff`.
  - Signed types sign-extend to XLEN; U types zero-extend.
  - Any funct3 code not valid for the configured XLEN is treated as a full-width load.
- `wb_regwrite[i] = valid & regwrite & (rd != 0)`. `wb_wdata` is still written for rd = 0.
- Same-rd conflict: if lanes i < j both request writes to the same nonzero rd in one cycle, lane j (younger, higher index) wins. Lane i's `wb_regwrite` is cleared; its `wb_valid` stays 1.
- Retire counter: on each non-stall cycle, adds popcount(`in_valid`). Wraps modulo 2^CNT_W.
- Stall, STALL_MODE=0: all `wb_*` registered to 0; counter unchanged.
- Stall, STALL_MODE=1: all `wb_*` and counter hold.
- Inputs presented during a stall are not captured. Upstream must hold them.

## Timing
- Latency: 1 cycle, inputs at edge N appear on outputs after edge N.
- No combinational path from input to output; all outputs come straight from registers.
- Reset: all `wb_*` outputs are 0 and `retire_count` is 0 after the first edge with reset=1.
- Priority order: reset > combined_stall > normal capture.
- Reset during a stall clears everything; the following non-stall cycle captures normally.
- Stall release: capture resumes on the first edge with `combined_stall=0`. No extra bubble is inserted.
- Counter at all-ones plus 2 retirements → 1 (wrap).

## Test plan
- **Reset:** reset=1 for 2 cycles with random inputs → all outputs 0, `retire_count`=0. Release → lane 0 (valid, ALU, rd=5, alu=0x1234) produces `wb_wdata=0x1234` and `wb_regwrite=1` one cycle later. `retire_count`=1.
- **Load extension:** rdata=0x80FF7F01, XLEN=32.
  - LB boff=3 → 0xFFFFFF80.
  - LBU boff=1 → 0x0000007F.
  - LH boff=2 → 0xFFFF80FF.
  - LHU boff=0 → 0x00007F01.
  - LW → 0x80FF7F01.
- **Conflict and x0:** lanes 0 and 1 both rd=7 → `wb_regwrite`=2'b10, both `wb_valid`=1. Lane with rd=0 → `wb_regwrite`=0, `wb_valid`=1.
- **Stall, mode 0:** capture a value, then stall 3 cycles → outputs 0 during the stall, counter frozen. On release, held inputs appear 1 cycle later.
- **Stall, mode 1:** same sequence → outputs equal pre-stall values throughout the stall, counter frozen.
- **Counter:** CNT_W=4, preset by 15 retirements, then 2 lanes valid → `retire_count`=1. Two-lane valid for 4 cycles increments by 8.
